// File: rtl/i_cache_pkg.sv
// rtl/i_cache_pkg.sv - shared encodings and widths for the instruction cache
package i_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  localparam int          BLOCK_W  = 128;
  localparam int          BADDR_W  = 28;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/i_cache_ctrl.sv
// rtl/i_cache_ctrl.sv - miss FSM and i_mem block-read handshake
import i_cache_pkg::*;

module i_cache_ctrl (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               i_miss,
  input  logic [BADDR_W-1:0] i_baddr,
  input  logic               i_mem_busywait,
  input  logic [BLOCK_W-1:0] i_mem_data,
  output state_t             o_state,
  output logic               o_mem_read,
  output logic [BADDR_W-1:0] o_mem_addr,
  output logic [BLOCK_W-1:0] o_fill_data,
  output logic               o_fill_we
);

  state_t               r_state;
  logic                 r_mem_read;
  logic [BADDR_W-1:0]   r_baddr;
  logic [BLOCK_W-1:0]   r_fill;

  // Only latched values drive the fill, so the CPU address may wander mid-miss.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_mem_read <= 1'b0;
      r_baddr    <= '0;
      r_fill     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_miss) begin
            r_baddr    <= i_baddr;
            r_mem_read <= 1'b1;
            r_state    <= ST_MEM_READ;
          end
        end
        ST_MEM_READ: begin
          if (!i_mem_busywait) begin
            r_fill     <= i_mem_data;
            r_mem_read <= 1'b0;
            r_state    <= ST_UPDATE;
          end
        end
        ST_UPDATE: r_state <= ST_IDLE;
        default: begin
          r_mem_read <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_state     = r_state;
  assign o_mem_read  = r_mem_read;
  assign o_mem_addr  = r_baddr;
  assign o_fill_data = r_fill;
  assign o_fill_we   = (r_state == ST_UPDATE);

endmodule

// File: rtl/i_cache.sv
// rtl/i_cache.sv - direct-mapped read-only instruction cache with combinational hit path
import i_cache_pkg::*;

module i_cache #(
  parameter int NUM_LINES = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic [31:0]         ADDRESS,
  output logic [31:0]         INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic [BADDR_W-1:0]  MEM_ADDR,
  input  logic [BLOCK_W-1:0]  MEM_READ_DATA,
  input  logic                MEM_BUSYWAIT
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = BADDR_W - INDEX_W;

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [BLOCK_W-1:0]   r_data [NUM_LINES];

  logic [INDEX_W-1:0]   w_index;
  logic [TAG_W-1:0]     w_tag;
  logic [1:0]           w_offset;
  logic [BLOCK_W-1:0]   w_block;
  logic [31:0]          w_word;
  logic                 w_hit;
  logic                 w_idle;
  logic                 w_miss;
  state_t               w_state;
  logic [BLOCK_W-1:0]   w_fill_data;
  logic                 w_fill_we;
  logic [INDEX_W-1:0]   w_fill_index;
  logic [TAG_W-1:0]     w_fill_tag;
  logic                 w_unused;

  assign w_offset = ADDRESS[3:2];
  assign w_index  = ADDRESS[3+INDEX_W:4];
  assign w_tag    = ADDRESS[31:4+INDEX_W];
  assign w_unused = &{1'b0, ADDRESS[1:0]};

  assign w_hit   = READ & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_block = r_data[w_index];
  assign w_word  = w_block[32*w_offset +: 32];
  assign w_idle  = (w_state == ST_IDLE);
  assign w_miss  = w_idle & READ & ~w_hit;

  assign INSTRUCTION = (w_idle & w_hit) ? w_word : NOP_INSN;
  assign BUSYWAIT    = w_idle ? (READ & ~w_hit) : 1'b1;

  // The latched block address already carries the target index and tag.
  assign w_fill_index = MEM_ADDR[INDEX_W-1:0];
  assign w_fill_tag   = MEM_ADDR[BADDR_W-1:INDEX_W];

  i_cache_ctrl u_ctrl (
    .CLK            (CLK),
    .RESET          (RESET),
    .i_miss         (w_miss),
    .i_baddr        (ADDRESS[31:4]),
    .i_mem_busywait (MEM_BUSYWAIT),
    .i_mem_data     (MEM_READ_DATA),
    .o_state        (w_state),
    .o_mem_read     (MEM_READ),
    .o_mem_addr     (MEM_ADDR),
    .o_fill_data    (w_fill_data),
    .o_fill_we      (w_fill_we)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
    end else if (w_fill_we) begin
      r_valid[w_fill_index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && w_fill_we) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= w_fill_data;
    end
  end

endmodule
